// File: rtl/pdm_rx_io.sv
// pdm_rx_io: PDM microphone slot - bit clock, 2-FF sync, boxcar ones-count decimator
// and a sample FIFO drained over the slot bus.
module pdm_rx_io #(
  parameter int          FIFO_AW = 4,
  parameter logic [15:0] DIV_RST = 16'd49
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        pdm_clk,
  input  logic        pdm_data
);
  localparam int DEPTH = 1 << FIFO_AW;
  logic               en_q, pdm_q, ovf_q, push_q;
  logic [15:0]        div_q, ctr_q, sample_q, sample_d, head;
  logic [3:0]         l_q, l_d;
  logic [1:0]         sync_q;
  logic [8:0]         ones_q, ones_tot, n_win;
  logic [7:0]         cnt_q;
  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]   count_q;
  logic wr_ctl, wr_l, clr, restart, tick, strobe, last, empty, full, pop, push_ok, unused;
  assign unused   = ^write_data[31:16];
  assign wr_ctl   = cs & write & (addr == 5'd2);
  assign wr_l     = cs & write & (addr == 5'd4);
  assign clr      = wr_ctl & write_data[1];
  assign restart  = clr | wr_l;
  assign tick     = en_q & (ctr_q == div_q);
  assign strobe   = tick & pdm_q;
  assign ones_tot = ones_q + 9'(sync_q[1]);
  assign n_win    = 9'd1 << l_q;
  assign last     = strobe & ({1'b0, cnt_q} == n_win - 9'd1);
  // ones_tot < N keeps the shifted count below 2^16, so subtracting 32768 is an MSB flip
  assign sample_d = (ones_tot == n_win) ? 16'h7FFF
                                        : (16'(ones_tot) << (5'd16 - {1'b0, l_q})) ^ 16'h8000;
  assign l_d      = (write_data[3:0] < 4'd4) ? 4'd4 : (write_data[3:0] > 4'd8) ? 4'd8 : write_data[3:0];
  assign empty    = (count_q == '0);
  assign full     = (count_q == (FIFO_AW+1)'(DEPTH));
  assign pop      = cs & read & (addr == 5'd0) & ~empty;
  assign push_ok  = push_q & (~full | pop);
  assign head     = mem_q[rp_q];
  assign pdm_clk  = pdm_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en_q     <= 1'b0;
      div_q    <= DIV_RST;
      l_q      <= 4'd6;
      ctr_q    <= '0;
      pdm_q    <= 1'b0;
      sync_q   <= '0;
      ones_q   <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      push_q   <= 1'b0;
    end else begin
      if (wr_ctl) en_q <= write_data[0];
      if (cs & write & (addr == 5'd3)) div_q <= write_data[15:0];
      if (wr_l) l_q <= l_d;
      ctr_q    <= (~en_q | tick) ? '0 : ctr_q + 16'd1;
      pdm_q    <= en_q & (pdm_q ^ tick);
      sync_q   <= {sync_q[0], pdm_data};
      ones_q   <= (restart | last) ? '0 : strobe ? ones_tot : ones_q;
      cnt_q    <= (restart | last) ? '0 : strobe ? cnt_q + 8'd1 : cnt_q;
      push_q   <= last & ~restart;
      if (last) sample_q <= sample_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      count_q <= count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
      ovf_q   <= (push_q & full & ~pop) | (ovf_q & ~(cs & write & (addr == 5'd1) & write_data[2]));
    end
  always_ff @(posedge clk)
    if (push_ok & ~clr) mem_q[wp_q] <= sample_q;
  always_comb begin
    read_data = '0;
    case (addr)
      5'd0:    read_data = empty ? '0 : {{16{head[15]}}, head};
      5'd1:    read_data = (32'(count_q) << 4) | {29'd0, ovf_q, full, empty};
      5'd2:    read_data = {31'd0, en_q};
      5'd3:    read_data = {16'd0, div_q};
      5'd4:    read_data = {28'd0, l_q};
      default: read_data = '0;
    endcase
  end
endmodule

// File: tb/tb_pdm_rx_io.sv
// tb_pdm_rx_io: random/directed PDM stimulus, window-level sample model and FIFO scoreboard
module tb_pdm_rx_io;
  logic        clk = 0, rst = 1, cs = 0, read = 0, write = 0, pdm_data = 0;
  logic [4:0]  addr = 0;
  logic [31:0] write_data = 0, read_data, pop_val, v;
  logic        pdm_clk;
  int total = 0, bad = 0, mode = 0, npush = 0;
  int q[$];
  int wcnt = 0, ones_m = 0, l_m = 6, pend_val = 0;
  bit ovf_m = 0, pend = 0, en_m = 0, en_prev = 0;
  event pop_ev;

  pdm_rx_io dut (.clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .addr(addr),
                 .write_data(write_data), .read_data(read_data), .pdm_clk(pdm_clk), .pdm_data(pdm_data));

  always #5 clk = ~clk;

  function automatic int exp_sample(int ones, int l);
    if (ones == (1 << l)) return 32'h7FFF;
    return ones * (1 << (16 - l)) - 32768;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Microphone: new bit shortly after each rising bit-clock edge
  initial forever begin
    @(posedge pdm_clk);
    #1;
    case (mode)
      0: pdm_data = 0;
      1: pdm_data = 1;
      2: pdm_data = (wcnt % 2 == 0);
      3: pdm_data = (wcnt % 16 < 12);
      default: pdm_data = 1'($urandom_range(0, 1));
    endcase
  end

  // Window model: each falling bit clock caused by counting captures one bit
  initial forever begin
    @(negedge pdm_clk);
    if (!rst && en_prev && !(cs && write && (addr == 4 || (addr == 2 && write_data[1])))) begin
      ones_m += pdm_data;
      wcnt++;
      if (wcnt == (1 << l_m)) begin
        pend = 1;
        pend_val = exp_sample(ones_m, l_m);
        wcnt = 0;
        ones_m = 0;
      end
    end
  end

  // Register/FIFO model, updated once per clock edge
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      en_prev = en_m;
      if (cs && write && addr == 2 && write_data[1]) begin
        q.delete();
        ovf_m = 0;
        pend = 0;
        wcnt = 0;
        ones_m = 0;
      end else begin
        if (cs && read && addr == 0 && q.size() > 0) void'(q.pop_front());
        if (cs && write && addr == 1 && write_data[2]) ovf_m = 0;
        if (pend) begin
          npush++;
          if (q.size() < 16) q.push_back(pend_val);
          else ovf_m = 1;
        end
        pend = 0;
      end
      if (cs && write && addr == 2) en_m = write_data[0];
      if (cs && write && addr == 4) begin
        l_m = write_data[3:0] < 4 ? 4 : write_data[3:0] > 8 ? 8 : int'(write_data[3:0]);
        wcnt = 0;
        ones_m = 0;
      end
    end
  end

  // Scoreboard monitor: every head read is checked against the expected FIFO front
  initial forever begin
    @(pop_ev);
    chk("pop_head", pop_val, q.size() > 0 ? q[0] : 0);
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1; write = 1; addr = a; write_data = d;
    @(negedge clk);
    cs = 0; write = 0;
  endtask

  task automatic rd_raw(input logic [4:0] a, output logic [31:0] r);
    cs = 1; read = 1; addr = a;
    #1;
    r = read_data;
    if (a == 0) begin
      pop_val = r;
      ->pop_ev;
    end
    @(negedge clk);
    cs = 0; read = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] r);
    @(negedge clk);
    rd_raw(a, r);
  endtask

  task automatic chk_status(input string nm);
    logic [31:0] e, r;
    @(negedge clk);
    e = {23'd0, 5'(q.size()), 1'b0, ovf_m, q.size() == 16, q.size() == 0};
    rd_raw(1, r);
    chk(nm, r, e);
  endtask

  task automatic wait_samples(input int n);
    int tgt = npush + n;
    for (int i = 0; i < 30000 && npush < tgt; i++) @(negedge clk);
    chk("sample_wait", 32'(npush >= tgt), 1);
  endtask

  task automatic wait_fall();
    logic p = pdm_clk;
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      if (p && !pdm_clk) begin
        ok = 1;
        break;
      end
      p = pdm_clk;
    end
    chk("fall_wait", 32'(ok), 1);
  endtask

  task automatic directed(input int m, input logic [31:0] e, input string nm);
    logic [31:0] r;
    mode = m;
    wait_fall();
    wait_fall();
    wr(2, 3);
    wait_samples(1);
    rd(0, r);
    chk(nm, r, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l;
    repeat (3) @(negedge clk);
    rst = 0;
    rd(1, v); chk("rst_status", v, 32'h1);
    rd(2, v); chk("rst_ctrl", v, 32'h0);
    rd(3, v); chk("rst_div", v, 32'd49);
    rd(4, v); chk("rst_L", v, 32'd6);
    rd(0, v); chk("rst_head", v, 32'h0);
    h = 0;
    repeat (200) @(negedge clk) if (pdm_clk) h++;
    chk("idle_pdm_low", h, 0);
    // Bit clock shape at div=1
    wr(3, 1);
    wr(2, 1);
    for (int i = 0; i < 50 && !pdm_clk; i++) @(negedge clk);
    h = 0;
    while (pdm_clk && h < 50) begin h++; @(negedge clk); end
    l = 0;
    while (!pdm_clk && l < 50) begin l++; @(negedge clk); end
    chk("pdm_high_cycles", h, 2);
    chk("pdm_low_cycles", l, 2);
    wr(2, 0);
    @(posedge clk);
    #1;
    chk("pdm_off_next_edge", pdm_clk, 0);
    h = 0;
    repeat (20) @(negedge clk) if (pdm_clk) h++;
    chk("pdm_stays_off", h, 0);
    // Decimation with L=4 and directed bit patterns
    wr(2, 2);
    wr(3, 3);
    wr(4, 4);
    mode = 1;
    wr(2, 1);
    directed(1, 32'h0000_7FFF, "L4_all_ones");
    directed(0, 32'hFFFF_8000, "L4_all_zeros");
    directed(2, 32'h0000_0000, "L4_alternating");
    directed(3, 32'h0000_4000, "L4_twelve_ones");
    wr(4, 2);  rd(4, v); chk("L_clamp_low", v, 32'd4);
    wr(4, 12); rd(4, v); chk("L_clamp_high", v, 32'd8);
    wr(4, 4);
    // Overflow after 17 unread windows
    mode = 4;
    wait_fall();
    wr(2, 3);
    wait_samples(17);
    rd(1, v); chk("full_ovf_status", v, 32'h106);
    for (int i = 0; i < 16; i++) rd(0, v);
    chk_status("after_drain");
    wr(1, 4);
    rd(1, v); chk("ovf_cleared", v[2], 0);
    // Pop aligned with a push while full
    wait_fall();
    wr(2, 3);
    wait_samples(16);
    chk_status("refilled");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pend) break;
    end
    chk("pend_seen", 32'(pend), 1);
    rd_raw(0, v);
    rd(1, v); chk("aligned_full_no_ovf", v, 32'h102);
    wr(2, 3);
    rd(0, v); chk("empty_head", v, 32'h0);
    chk_status("empty_after_read");
    // Clear in the middle of a window
    repeat (5) wait_fall();
    wr(2, 3);
    wait_samples(1);
    rd(0, v);
    chk_status("after_mid_clear");
    // Asynchronous reset in the middle of a window
    repeat (3) wait_fall();
    for (int i = 0; i < 50 && !pdm_clk; i++) @(negedge clk);
    chk("pdm_high_before_rst", pdm_clk, 1);
    #2;
    rst = 1;
    #1;
    chk("rst_async_pdm", pdm_clk, 0);
    q.delete(); ovf_m = 0; pend = 0; wcnt = 0; ones_m = 0; en_m = 0; en_prev = 0; l_m = 6;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_status("after_rst");
    rd(3, v); chk("div_after_rst", v, 32'd49);
    wr(3, 3);
    wr(4, 4);
    wr(2, 1);
    wait_samples(1);
    rd(0, v);
    // Random data at other window lengths
    wait_fall();
    wr(4, 5);
    wait_samples(2);
    rd(0, v);
    rd(0, v);
    wait_fall();
    wr(4, 8);
    wait_samples(1);
    rd(0, v);
    chk_status("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
